// File: rtl/tri_point_tester_if.sv
// Request/response bundle for tri_point_tester.
//   Request : i_valid, o_ready, p1x..pty  (triangle vertices P1..P3 and test point PT)
//   Response: o_valid, i_ready, o_inside, o_degen, o_area2
// The master modport belongs to the requester, and the slave modport belongs to the tester.
interface tri_point_tester_if #(
  parameter int W = 12
);
  logic           i_valid;
  logic           o_ready;
  logic [W-1:0]   p1x, p1y;
  logic [W-1:0]   p2x, p2y;
  logic [W-1:0]   p3x, p3y;
  logic [W-1:0]   ptx, pty;
  logic           o_valid;
  logic           i_ready;
  logic           o_inside;
  logic           o_degen;
  logic [2*W+1:0] o_area2;

  modport master (
    output i_valid, p1x, p1y, p2x, p2y, p3x, p3y, ptx, pty, i_ready,
    input  o_ready, o_valid, o_inside, o_degen, o_area2
  );

  modport slave (
    input  i_valid, p1x, p1y, p2x, p2y, p3x, p3y, ptx, pty, i_ready,
    output o_ready, o_valid, o_inside, o_degen, o_area2
  );
endinterface

// File: rtl/tri_point_tester.sv
// Sequential point-in-triangle responder using the area-sum test.
// PT is inside iff 2A(P1P2P3) == 2A(P1P2PT) + 2A(P2P3PT) + 2A(P3P1PT).
// One shared multiplier evaluates the 12 cross terms, one term per cycle.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous active-high reset
//   bus      tri_point_tester_if.slave (request coords, result verdict/area)
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | o_ready=1, waiting for i_valid; coords latched on accept
// CALC  | 12 cycles, one multiply-accumulate term per cycle
// CMP   | 1 cycle, compare A0 against A1+A2+A3, register result
// RESP  | o_valid held until i_ready
module tri_point_tester #(
  parameter int W = 12
) (
  input  logic          i_clock,
  input  logic          i_reset,
  tri_point_tester_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CMP, S_RESP} state_t;

  localparam logic [2*W+1:0] ONE_A = 1;

  state_t         r_state, w_state_next;
  logic [W-1:0]   r_x [4];
  logic [W-1:0]   r_y [4];
  logic [1:0]     r_k;
  logic [1:0]     r_term;
  logic signed [2*W+2:0] r_acc;
  logic [2*W+1:0] r_area [4];
  logic           r_ready, r_valid, r_inside, r_degen;
  logic [2*W+1:0] r_area2;

  logic [1:0]     w_va, w_vb, w_vc;
  logic [1:0]     w_vx, w_vy1, w_vy2;
  logic signed [W:0]     w_diff;
  logic signed [2*W:0]   w_prod;
  logic signed [2*W+2:0] w_acc_sum;
  logic [2*W+1:0] w_abs;
  logic [2*W+3:0] w_sum;
  logic           w_accept;
  logic           w_last_term;

  assign w_accept    = bus.i_valid && r_ready && (r_state == S_IDLE);
  assign w_last_term = (r_term == 2'd2);

  // Vertex indices: 0=P1 1=P2 2=P3 3=PT. Triple k selects (a,b,c).
  always_comb begin
    w_va = 2'd0;
    w_vb = 2'd1;
    w_vc = 2'd2;
    case (r_k)
      2'd0: begin w_va = 2'd0; w_vb = 2'd1; w_vc = 2'd2; end
      2'd1: begin w_va = 2'd0; w_vb = 2'd1; w_vc = 2'd3; end
      2'd2: begin w_va = 2'd1; w_vb = 2'd2; w_vc = 2'd3; end
      default: begin w_va = 2'd2; w_vb = 2'd0; w_vc = 2'd3; end
    endcase
  end

  // Cyclic term pattern: xa*(yb-yc), xb*(yc-ya), xc*(ya-yb).
  always_comb begin
    w_vx  = w_va;
    w_vy1 = w_vb;
    w_vy2 = w_vc;
    case (r_term)
      2'd0: begin w_vx = w_va; w_vy1 = w_vb; w_vy2 = w_vc; end
      2'd1: begin w_vx = w_vb; w_vy1 = w_vc; w_vy2 = w_va; end
      default: begin w_vx = w_vc; w_vy1 = w_va; w_vy2 = w_vb; end
    endcase
  end

  assign w_diff = $signed({1'b0, r_y[w_vy1]}) - $signed({1'b0, r_y[w_vy2]});

  // Both operands widened to the product width; |x*d| < 2^(2W) so nothing is lost.
  assign w_prod = $signed({{(W+1){1'b0}}, r_x[w_vx]}) * $signed({{W{w_diff[W]}}, w_diff});

  assign w_acc_sum = r_acc + {{2{w_prod[2*W]}}, w_prod};

  // The magnitude of the sum always fits in 2W+2 bits, so the sign bit can be dropped after negation.
  assign w_abs = w_acc_sum[2*W+2] ? (~w_acc_sum[2*W+1:0] + ONE_A) : w_acc_sum[2*W+1:0];

  assign w_sum = {2'b00, r_area[1]} + {2'b00, r_area[2]} + {2'b00, r_area[3]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_CALC;
      S_CALC: if (w_last_term && r_k == 2'd3) w_state_next = S_CMP;
      S_CMP:  w_state_next = S_RESP;
      S_RESP: if (bus.i_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) begin
        r_x[i]    <= '0;
        r_y[i]    <= '0;
        r_area[i] <= '0;
      end
      r_k      <= '0;
      r_term   <= '0;
      r_acc    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_inside <= 1'b0;
      r_degen  <= 1'b0;
      r_area2  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x[0]  <= bus.p1x;  r_y[0] <= bus.p1y;
            r_x[1]  <= bus.p2x;  r_y[1] <= bus.p2y;
            r_x[2]  <= bus.p3x;  r_y[2] <= bus.p3y;
            r_x[3]  <= bus.ptx;  r_y[3] <= bus.pty;
            r_k     <= '0;
            r_term  <= '0;
            r_acc   <= '0;
            r_ready <= 1'b0;
          end
        end
        S_CALC: begin
          if (w_last_term) begin
            r_area[r_k] <= w_abs;
            r_acc       <= '0;
            r_term      <= '0;
            r_k         <= r_k + 2'd1;
          end else begin
            r_acc  <= w_acc_sum;
            r_term <= r_term + 2'd1;
          end
        end
        S_CMP: begin
          r_area2  <= r_area[0];
          r_degen  <= (r_area[0] == '0);
          r_inside <= (r_area[0] != '0) && ({2'b00, r_area[0]} == w_sum);
          r_valid  <= 1'b1;
        end
        S_RESP: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready  = r_ready;
  assign bus.o_valid  = r_valid;
  assign bus.o_inside = r_inside;
  assign bus.o_degen  = r_degen;
  assign bus.o_area2  = r_area2;

endmodule

// File: tb/tb_tri_point_tester.sv
// Directed self-checking bench for tri_point_tester.
module tb_tri_point_tester;
  typedef int coord_t [8];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  tri_point_tester_if #(.W(12)) bus();

  tri_point_tester #(.W(12)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_coords(input coord_t c);
    bus.p1x = 12'(c[0]); bus.p1y = 12'(c[1]);
    bus.p2x = 12'(c[2]); bus.p2y = 12'(c[3]);
    bus.p3x = 12'(c[4]); bus.p3y = 12'(c[5]);
    bus.ptx = 12'(c[6]); bus.pty = 12'(c[7]);
  endtask

  task automatic scramble_coords();
    coord_t c;
    for (int i = 0; i < 8; i++) c[i] = int'($urandom_range(0, 4095));
    set_coords(c);
  endtask

  // Waits for o_ready, issues one request, scrambles inputs after the accepting
  // edge and counts edges until o_valid (lat = 13 on time, 40 on timeout).
  task automatic send_request(input coord_t c, output int lat);
    int w = 0;
    while (bus.o_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    bus.i_valid = 1'b1;
    set_coords(c);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    scramble_coords();
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    coord_t z = '{0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    set_coords(z);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready: got %b expected 1", bus.o_ready); end
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_inside !== 1'b0) begin failures++; $display("FAIL reset_o_inside: got %b expected 0", bus.o_inside); end
    checks++; if (bus.o_degen !== 1'b0) begin failures++; $display("FAIL reset_o_degen: got %b expected 0", bus.o_degen); end
    checks++; if (bus.o_area2 !== 26'd0) begin failures++; $display("FAIL reset_o_area2: got %0d expected 0", bus.o_area2); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Vectors 1..5 issued back to back with i_ready held high.
  task automatic test_vectors();
    coord_t vecs [5] = '{
      '{2, 23, 1, 25, 6, 25, 5, 23},
      '{0, 0, 10, 0, 0, 10, 2, 2},
      '{0, 0, 10, 0, 0, 10, 5, 5},
      '{0, 0, 5, 5, 10, 10, 1, 1},
      '{0, 0, 4095, 0, 0, 4095, 4095, 4095}
    };
    logic        exp_in [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_dg [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [25:0] exp_ar [5] = '{26'd10, 26'd100, 26'd100, 26'd0, 26'd16769025};
    int lat;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_request(vecs[i], lat);
      checks++; if (lat !== 13) begin failures++; $display("FAIL vec%0d_latency: got %0d expected 13", i + 1, lat); end
      checks++; if (bus.o_inside !== exp_in[i]) begin failures++; $display("FAIL vec%0d_inside: got %b expected %b", i + 1, bus.o_inside, exp_in[i]); end
      checks++; if (bus.o_degen !== exp_dg[i]) begin failures++; $display("FAIL vec%0d_degen: got %b expected %b", i + 1, bus.o_degen, exp_dg[i]); end
      checks++; if (bus.o_area2 !== exp_ar[i]) begin failures++; $display("FAIL vec%0d_area2: got %0d expected %0d", i + 1, bus.o_area2, exp_ar[i]); end
      @(posedge clk); #1;
      checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_valid_drop: got %b expected 0", i + 1, bus.o_valid); end
      checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL vec%0d_ready_back: got %b expected 1", i + 1, bus.o_ready); end
      checks++; if (bus.o_area2 !== exp_ar[i]) begin failures++; $display("FAIL vec%0d_area2_hold: got %0d expected %0d", i + 1, bus.o_area2, exp_ar[i]); end
    end
  endtask

  task automatic test_backpressure();
    coord_t t2 = '{0, 0, 10, 0, 0, 10, 2, 2};
    coord_t other = '{0, 0, 5, 5, 10, 10, 1, 1};
    int lat;
    bit seen;
    bus.i_ready = 1'b0;
    send_request(t2, lat);
    checks++; if (lat !== 13) begin failures++; $display("FAIL bp_latency: got %0d expected 13", lat); end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.i_valid = 1'b1;
        set_coords(other);
      end
      @(posedge clk); #1;
      checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, bus.o_valid); end
      checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready%0d: got %b expected 0", i, bus.o_ready); end
      checks++; if (bus.o_inside !== 1'b1) begin failures++; $display("FAIL bp_hold_inside%0d: got %b expected 1", i, bus.o_inside); end
      checks++; if (bus.o_area2 !== 26'd100) begin failures++; $display("FAIL bp_hold_area2%0d: got %0d expected 100", i, bus.o_area2); end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", bus.o_ready); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.o_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL bp_ignored_request: got o_valid=%b expected never 1", seen); end
  endtask

  task automatic test_reset_mid_calc();
    coord_t t1 = '{2, 23, 1, 25, 6, 25, 5, 23};
    coord_t t2 = '{0, 0, 10, 0, 0, 10, 2, 2};
    int lat;
    bit seen;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    set_coords(t1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL calc_busy_ready: got %b expected 0", bus.o_ready); end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready: got %b expected 1", bus.o_ready); end
    checks++; if (bus.o_area2 !== 26'd0) begin failures++; $display("FAIL midreset_area2: got %0d expected 0", bus.o_area2); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.o_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_dropped: got o_valid=%b expected never 1", seen); end
    send_request(t2, lat);
    checks++; if (lat !== 13) begin failures++; $display("FAIL post_reset_latency: got %0d expected 13", lat); end
    checks++; if (bus.o_inside !== 1'b1) begin failures++; $display("FAIL post_reset_inside: got %b expected 1", bus.o_inside); end
    checks++; if (bus.o_area2 !== 26'd100) begin failures++; $display("FAIL post_reset_area2: got %0d expected 100", bus.o_area2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_resp();
    coord_t t3 = '{0, 0, 10, 0, 0, 10, 5, 5};
    int lat;
    bus.i_ready = 1'b0;
    send_request(t3, lat);
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL resp_before_reset_valid: got %b expected 1", bus.o_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL resp_reset_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_inside !== 1'b0) begin failures++; $display("FAIL resp_reset_inside: got %b expected 0", bus.o_inside); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL resp_reset_ready: got %b expected 1", bus.o_ready); end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_calc();
    test_reset_mid_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
